// File: rtl/frame_section_router.sv
// Tags the payload bytes that follow each MP3 frame header as CRC, side info or main data.
// Optional macro CRC_STRIP_EN: CRC bytes are absorbed into crc_word instead of being forwarded.
module frame_section_router #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned HDR_BYTES       = 4,
    parameter int unsigned CRC_BYTES       = 2,
    parameter int unsigned SI_MONO_BYTES   = 17,
    parameter int unsigned SI_STEREO_BYTES = 32,
    parameter int unsigned FSIZE_W         = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axiiv,
    input  logic [DATA_W-1:0]  axiid,
    input  logic               valid_header,
    input  logic [1:0]         mode,
    input  logic               prot,
    input  logic [FSIZE_W-1:0] frame_size,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_out_valid,
    output logic               crc_16_ov,
    output logic               side_info_ov,
    output logic               fifo_buffer_ov,
    output logic               frame_done,
    output logic               frame_err,
    output logic [FSIZE_W-1:0] bytes_left,
    output logic [15:0]        crc_word
);

    localparam int unsigned EW = FSIZE_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CRC  = 2'd1;
    localparam logic [1:0] ST_SIDE = 2'd2;
    localparam logic [1:0] ST_MAIN = 2'd3;

    localparam logic [EW-1:0]      ONE_E = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [FSIZE_W-1:0] ONE_F = {{(FSIZE_W-1){1'b0}}, 1'b1};
    localparam logic [FSIZE_W-1:0] HDR_F = FSIZE_W'(HDR_BYTES);

    logic [1:0]         state_q, state_d;
    logic [EW-1:0]      sec_cnt_q, sec_cnt_d;
    logic [EW-1:0]      side_len_q, side_len_d;
    logic [EW-1:0]      main_len_q, main_len_d;
    logic [FSIZE_W-1:0] bytes_left_q, bytes_left_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               dov_q, dov_d;
    logic               crc_f_q, crc_f_d;
    logic               side_f_q, side_f_d;
    logic               fifo_f_q, fifo_f_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Header-time section sizing, evaluated one bit wider than frame_size
    logic [EW-1:0] hdr_side;
    logic [EW-1:0] hdr_crc;
    logic [EW-1:0] hdr_need;
    logic [EW-1:0] fsize_ext;
    logic [EW-1:0] hdr_main;
    logic          hdr_short;
    logic          accept;
    logic          sec_last;

    always_comb begin
        hdr_side  = (mode == 2'b11) ? EW'(SI_MONO_BYTES) : EW'(SI_STEREO_BYTES);
        hdr_crc   = prot ? '0 : EW'(CRC_BYTES);
        hdr_need  = EW'(HDR_BYTES) + hdr_crc + hdr_side;
        fsize_ext = {1'b0, frame_size};
        hdr_short = fsize_ext < hdr_need;
        hdr_main  = fsize_ext - hdr_need;
    end

    assign accept   = axiiv && (state_q != ST_IDLE) && !valid_header;
    assign sec_last = (sec_cnt_q == ONE_E);

`ifdef CRC_STRIP_EN
    logic [15:0] crc_word_q, crc_word_d;
`endif

    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        side_len_d   = side_len_q;
        main_len_d   = main_len_q;
        bytes_left_d = bytes_left_q;
        data_out_d   = data_out_q;
        dov_d        = 1'b0;
        crc_f_d      = 1'b0;
        side_f_d     = 1'b0;
        fifo_f_d     = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef CRC_STRIP_EN
        crc_word_d   = crc_word_q;
`endif

        if (valid_header) begin
            // A header in any state restarts framing; outside IDLE the old frame was truncated
`ifdef CRC_STRIP_EN
            crc_word_d = '0;
`endif
            if (hdr_short) begin
                err_d        = 1'b1;
                state_d      = ST_IDLE;
                sec_cnt_d    = '0;
                bytes_left_d = '0;
            end else begin
                err_d        = (state_q != ST_IDLE);
                side_len_d   = hdr_side;
                main_len_d   = hdr_main;
                bytes_left_d = frame_size - HDR_F;
                if (hdr_crc != '0) begin
                    state_d   = ST_CRC;
                    sec_cnt_d = hdr_crc;
                end else begin
                    state_d   = ST_SIDE;
                    sec_cnt_d = hdr_side;
                end
            end
        end else if (accept) begin
            if (bytes_left_q != '0) begin
                bytes_left_d = bytes_left_q - ONE_F;
            end
            sec_cnt_d = sec_cnt_q - ONE_E;
            case (state_q)
                ST_CRC: begin
`ifdef CRC_STRIP_EN
                    crc_word_d = 16'({crc_word_q, axiid});
`else
                    dov_d      = 1'b1;
                    crc_f_d    = 1'b1;
                    data_out_d = axiid;
`endif
                    if (sec_last) begin
                        state_d   = ST_SIDE;
                        sec_cnt_d = side_len_q;
                    end
                end
                ST_SIDE: begin
                    dov_d      = 1'b1;
                    side_f_d   = 1'b1;
                    data_out_d = axiid;
                    if (sec_last) begin
                        if (main_len_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = ST_MAIN;
                            sec_cnt_d = main_len_q;
                        end
                    end
                end
                ST_MAIN: begin
                    dov_d      = 1'b1;
                    fifo_f_d   = 1'b1;
                    data_out_d = axiid;
                    if (sec_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= '0;
            side_len_q   <= '0;
            main_len_q   <= '0;
            bytes_left_q <= '0;
            data_out_q   <= '0;
            dov_q        <= 1'b0;
            crc_f_q      <= 1'b0;
            side_f_q     <= 1'b0;
            fifo_f_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            side_len_q   <= side_len_d;
            main_len_q   <= main_len_d;
            bytes_left_q <= bytes_left_d;
            data_out_q   <= data_out_d;
            dov_q        <= dov_d;
            crc_f_q      <= crc_f_d;
            side_f_q     <= side_f_d;
            fifo_f_q     <= fifo_f_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef CRC_STRIP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_word_q <= '0;
        end else begin
            crc_word_q <= crc_word_d;
        end
    end

    assign crc_word = crc_word_q;
`else
    assign crc_word = '0;
`endif

    assign data_out       = data_out_q;
    assign data_out_valid = dov_q;
    assign crc_16_ov      = crc_f_q;
    assign side_info_ov   = side_f_q;
    assign fifo_buffer_ov = fifo_f_q;
    assign frame_done     = done_q;
    assign frame_err      = err_q;
    assign bytes_left     = bytes_left_q;

endmodule

// File: doc/frame_section_router.md
Name: frame_section_router

Overview:
- Parametrised successor to the existing fixed-layout byte multiplexer in the MP3 parse chain.
- Sits between header_finder and the section consumers: CRC checker, side_info parser, main-data FIFO.
- On each detected frame header, it tags every following payload byte as CRC, side-info or main data, using per-frame mode, protection and size.
- New relative to the fixed mux: configurable header/side-info sizes, per-frame byte accounting, a frame_done pulse, resync on an early header, and short-frame error detection.

Parameters:
- DATA_W, 8, byte-lane width of axiid/data_out
- HDR_BYTES, 4, header bytes already consumed by header_finder
- CRC_BYTES, 2, CRC bytes present when prot==0
- SI_MONO_BYTES, 17, side-info bytes when mode==2'b11
- SI_STEREO_BYTES, 32, side-info bytes for any other mode
- FSIZE_W, 11, width of frame_size and byte counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiiv  in  1  input byte valid
- axiid  in  DATA_W  input byte
- valid_header  in  1  one-cycle pulse; mode/prot/frame_size valid in the same cycle
- mode  in  2  channel mode (2'b11 = mono)
- prot  in  1  protection bit (0 = CRC present)
- frame_size  in  FSIZE_W  total frame bytes, header included
- data_out  out  DATA_W  registered copy of the accepted byte
- data_out_valid  out  1  data_out qualifier
- crc_16_ov  out  1  current output byte is CRC
- side_info_ov  out  1  current output byte is side info
- fifo_buffer_ov  out  1  current output byte is main data
- frame_done  out  1  one-cycle pulse with the last main-data byte
- frame_err  out  1  one-cycle pulse on truncated or undersized frame
- bytes_left  out  FSIZE_W  bytes remaining in the current frame
- crc_word  out  16  captured CRC (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, CRC, SIDE, MAIN.
- A byte is accepted when axiiv=1 in CRC, SIDE or MAIN. Bytes are dropped in IDLE, and on a cycle where valid_header=1 (that byte belongs to the header).
- Latency: exactly 1 cycle.
  - data_out, data_out_valid and the flags register the accepted byte.
  - Exactly one flag is high whenever data_out_valid=1.
  - All flags are 0 when data_out_valid=0.
- IDLE + valid_header:
  - Latch side_len = (mode==2'b11) ? SI_MONO_BYTES : SI_STEREO_BYTES.
  - Latch crc_len = prot ? 0 : CRC_BYTES.
  - Compute main_len = frame_size − HDR_BYTES − crc_len − side_len, at full FSIZE_W+1 width.
  - Next state is CRC if crc_len≠0, else SIDE.
  - Load bytes_left = frame_size − HDR_BYTES.
- Undersized frame:
  - If frame_size < HDR_BYTES+crc_len+side_len, pulse frame_err next cycle and stay in IDLE.
  - No bytes are forwarded for that frame.
- Section counters:
  - A section counter loads the section length on entry and decrements per accepted byte.
  - On the last byte of a section, advance CRC→SIDE→MAIN.
  - If main_len==0, go SIDE→IDLE directly and pulse frame_done with the last side-info byte.
- Leaving MAIN: the last main-data byte returns the FSM to IDLE. frame_done is asserted together with that byte's data_out_valid.
- bytes_left decrements by 1 per accepted byte, reads 0 in IDLE after a frame, and never wraps.
- valid_header while not in IDLE:
  - Truncated frame: pulse frame_err the next cycle.
  - Immediately re-latch parameters and restart as from IDLE; the same-cycle byte is dropped.
  - frame_done is not pulsed for the truncated frame.
- axiiv gaps: counters and state hold. No timeout.
- rst asserted mid-frame: next cycle returns everything to reset values, with no frame_done or frame_err pulse.

Optional Feature:
- Macro: CRC_STRIP_EN.
- Defined:
  - CRC bytes are not forwarded: data_out_valid and crc_16_ov stay 0 during CRC.
  - CRC bytes are shifted MSB-first into crc_word, which is held until the next valid_header and cleared by rst.
- Undefined:
  - CRC bytes are forwarded with crc_16_ov=1.
  - crc_word is tied to 0.

Test Plan:
- Stereo (mode=00), prot=1, frame_size=417, 413 contiguous bytes → 32 side_info_ov bytes, then 381 fifo_buffer_ov bytes, no crc_16_ov, frame_done on output byte 413, bytes_left=0.
- Mono (mode=11), prot=0, frame_size=104, 100 bytes →
  - Without CRC_STRIP_EN: 2 crc, 17 side, 81 main.
  - With CRC_STRIP_EN: 0 crc outputs, crc_word = first two bytes (e.g. 8'hAB,8'hCD → 16'hABCD).
- Same stereo frame with axiiv toggling 1/0 every cycle → identical output byte sequence and section tagging, each output 1 cycle after its accepted input.
- valid_header re-pulsed after 50 main bytes of a 417-byte frame → frame_err pulse, no frame_done, new frame tagged from its first byte.
- Undersized frame: frame_size=20, prot=0, stereo → frame_err, FSM stays IDLE, subsequent bytes dropped.
- rst asserted after 10 side-info bytes → all outputs 0 next cycle; following bytes dropped until the next valid_header.
